// File: rtl/fcl_loop_pkg.sv
// Shared types and constants for the fully-connected-layer loop controller.
//   lc_state_e      : controller FSM state encoding
//   MAC_LAT_DEFAULT : default MAC pipeline latency in cycles
//   DRAIN_W         : width of the drain counter (covers MAC_LAT 0..15)
package fcl_loop_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4,
    ST_FIN   = 3'd5
  } lc_state_e;

  localparam int unsigned MAC_LAT_DEFAULT = 2;
  localparam int unsigned DRAIN_W         = 4;

endpackage

// File: rtl/loop_idx_cnt.sv
// Loop index counter: synchronous clear, increment, equality-to-last flag.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   i_clr       : clear index to zero (wins over i_inc)
//   i_inc       : increment index by one
//   i_last      : final index value of the loop
//   o_idx       : current index (registered)
//   o_at_last_c : combinational flag, o_idx == i_last
module loop_idx_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_idx,
  output logic         o_at_last_c
);

  logic [W-1:0] r_idx;

  // Index register
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + W'(1);
    end
  end

  assign o_idx       = r_idx;
  // Equality only, so a full-range loop (last = all ones) ends without wrapping
  assign o_at_last_c = (r_idx == i_last);

endmodule

// File: rtl/fcl_loop_ctrl.sv
// Loop controller for a fully-connected layer: for each output neuron it
// clears the accumulator, streams every input index to the MAC, waits out the
// MAC pipeline, then hands the neuron result to a writeback sink.
//   lc_clk, lc_rst          : clock / synchronous active-high reset
//   lc_start                : start pulse, honoured only in IDLE
//   lc_in_last, lc_out_last : last input / neuron index, captured at start
//   lc_busy                 : high outside IDLE
//   lc_in_idx, lc_out_idx   : current input / neuron index
//   lc_acc_clr, lc_mac_en   : accumulator clear / MAC enable strobes
//   lc_res_valid/_ready/_idx: result writeback handshake
//   lc_done                 : one-cycle pulse after the last writeback
module fcl_loop_ctrl
  import fcl_loop_pkg::*;
#(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 7,
  parameter int unsigned MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic             lc_clk,
  input  logic             lc_rst,
  input  logic             lc_start,
  input  logic [IN_W-1:0]  lc_in_last,
  input  logic [OUT_W-1:0] lc_out_last,
  output logic             lc_busy,
  output logic [IN_W-1:0]  lc_in_idx,
  output logic [OUT_W-1:0] lc_out_idx,
  output logic             lc_acc_clr,
  output logic             lc_mac_en,
  output logic             lc_res_valid,
  input  logic             lc_res_ready,
  output logic [OUT_W-1:0] lc_res_idx,
  output logic             lc_done
);

  localparam bit HAS_DRAIN = (MAC_LAT > 0);
  // Drain counts down to zero, so MAC_LAT cycles need a load of MAC_LAT-1
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
    HAS_DRAIN ? DRAIN_W'(MAC_LAT - 1) : '0;

  lc_state_e          r_state;
  lc_state_e          w_nxt_state;
  logic [IN_W-1:0]    r_in_last;
  logic [OUT_W-1:0]   r_out_last;
  logic [DRAIN_W-1:0] r_drain_cnt;

  logic               r_busy;
  logic               r_acc_clr;
  logic               r_mac_en;
  logic               r_res_valid;
  logic               r_done;
  logic [OUT_W-1:0]   r_res_idx;

  logic               w_capture;
  logic               w_wb_hs;
  logic               w_in_clr;
  logic               w_in_inc;
  logic               w_in_at_last;
  logic [IN_W-1:0]    w_in_idx;
  logic               w_out_inc;
  logic               w_out_at_last;
  logic [OUT_W-1:0]   w_out_idx;
  logic               w_nxt_busy;
  logic               w_nxt_acc_clr;
  logic               w_nxt_mac_en;
  logic               w_nxt_res_valid;
  logic               w_nxt_done;
  logic [OUT_W-1:0]   w_nxt_res_idx;

  // Input-element index
  loop_idx_cnt #(.W(IN_W)) u_in_cnt (
    .clk         (lc_clk),
    .rst         (lc_rst),
    .i_clr       (w_in_clr),
    .i_inc       (w_in_inc),
    .i_last      (r_in_last),
    .o_idx       (w_in_idx),
    .o_at_last_c (w_in_at_last)
  );

  // Output-neuron index
  loop_idx_cnt #(.W(OUT_W)) u_out_cnt (
    .clk         (lc_clk),
    .rst         (lc_rst),
    .i_clr       (w_capture),
    .i_inc       (w_out_inc),
    .i_last      (r_out_last),
    .o_idx       (w_out_idx),
    .o_at_last_c (w_out_at_last)
  );

  // State and output registers
  always_ff @(posedge lc_clk) begin
    if (lc_rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      r_res_idx   <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_busy      <= w_nxt_busy;
      r_acc_clr   <= w_nxt_acc_clr;
      r_mac_en    <= w_nxt_mac_en;
      r_res_valid <= w_nxt_res_valid;
      r_done      <= w_nxt_done;
      r_res_idx   <= w_nxt_res_idx;
    end
  end

  // Next state; outputs are decoded from the next state so they are registered
  always_comb begin
    w_nxt_state = r_state;
    w_capture   = 1'b0;
    w_wb_hs     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (lc_start) begin
          w_capture   = 1'b1;
          w_nxt_state = ST_CLR;
        end
      end
      ST_CLR:   w_nxt_state = ST_RUN;
      ST_RUN: begin
        if (w_in_at_last) begin
          w_nxt_state = HAS_DRAIN ? ST_DRAIN : ST_WB;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_nxt_state = ST_WB;
        end
      end
      ST_WB: begin
        if (lc_res_ready) begin
          w_wb_hs     = 1'b1;
          w_nxt_state = w_out_at_last ? ST_FIN : ST_CLR;
        end
      end
      ST_FIN:   w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase

    w_in_clr        = (w_nxt_state == ST_CLR);
    w_in_inc        = (r_state == ST_RUN) && !w_in_at_last;
    w_out_inc       = w_wb_hs && !w_out_at_last;

    w_nxt_busy      = (w_nxt_state != ST_IDLE);
    w_nxt_acc_clr   = (w_nxt_state == ST_CLR);
    w_nxt_mac_en    = (w_nxt_state == ST_RUN);
    w_nxt_res_valid = (w_nxt_state == ST_WB);
    w_nxt_done      = (w_nxt_state == ST_FIN);
    // Neuron index is stable across WB: it only advances on the handshake edge
    w_nxt_res_idx   = (w_nxt_state == ST_WB) ? w_out_idx : '0;
  end

  // Captured loop limits
  always_ff @(posedge lc_clk) begin
    if (lc_rst) begin
      r_in_last  <= '0;
      r_out_last <= '0;
    end else if (w_capture) begin
      r_in_last  <= lc_in_last;
      r_out_last <= lc_out_last;
    end
  end

  // Drain counter: primed during RUN, counts down through DRAIN
  always_ff @(posedge lc_clk) begin
    if (lc_rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_drain_cnt <= DRAIN_LOAD;
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
    end
  end

  assign lc_busy      = r_busy;
  assign lc_in_idx    = w_in_idx;
  assign lc_out_idx   = w_out_idx;
  assign lc_acc_clr   = r_acc_clr;
  assign lc_mac_en    = r_mac_en;
  assign lc_res_valid = r_res_valid;
  assign lc_res_idx   = r_res_idx;
  assign lc_done      = r_done;

endmodule

// File: doc/fcl_loop_ctrl.md
FCL_LOOP_CTRL -- requirements
Module: fcl_loop_ctrl

Interface
REQ-001 Parameter IN_W, default 8, width of the input-element index.
REQ-002 Parameter OUT_W, default 7, width of the output-neuron index.
REQ-003 Parameter MAC_LAT, default 2, MAC pipeline latency in cycles; legal range 0..15.
REQ-004 lc_clk  in  1  the only clock; all logic on the rising edge.
REQ-005 lc_rst  in  1  reset, synchronous, active-high.
REQ-006 lc_start  in  1  start pulse; sampled only in IDLE.
REQ-007 lc_in_last  in  IN_W  last input index (input length minus 1); captured at start.
REQ-008 lc_out_last  in  OUT_W  last neuron index (neuron count minus 1); captured at start.
REQ-009 lc_busy  out  1  high in every state except IDLE.
REQ-010 lc_in_idx  out  IN_W  current input-element index.
REQ-011 lc_out_idx  out  OUT_W  current neuron index.
REQ-012 lc_acc_clr  out  1  accumulator-clear strobe.
REQ-013 lc_mac_en  out  1  MAC enable; lc_in_idx is valid while it is high.
REQ-014 lc_res_valid  out  1  neuron result is ready for writeback.
REQ-015 lc_res_ready  in  1  writeback sink can accept the result.
REQ-016 lc_res_idx  out  OUT_W  neuron index that goes with lc_res_valid.
REQ-017 lc_done  out  1  one-cycle pulse after the last neuron is written back.

Function
REQ-018 The FSM SHALL have the states IDLE, CLR, RUN, DRAIN, WB and FIN.
REQ-019 IDLE: lc_start=1 captures lc_in_last and lc_out_last, sets lc_out_idx=0, and goes to CLR; otherwise the FSM stays in IDLE.
REQ-020 CLR: lc_acc_clr=1 for exactly one cycle, lc_in_idx=0, then RUN.
REQ-021 RUN: lc_mac_en=1 every cycle.
REQ-022 RUN: lc_in_idx increments by 1 per cycle.
REQ-023 RUN: the cycle with lc_in_idx equal to captured in_last is the final RUN cycle.
REQ-024 RUN exit: to DRAIN if MAC_LAT>0, else to WB.
REQ-025 DRAIN: lc_mac_en=0 for exactly MAC_LAT cycles, then WB.
REQ-026 WB: lc_res_valid=1 and lc_res_idx=lc_out_idx.
REQ-027 WB: both outputs SHALL stay stable until lc_res_valid and lc_res_ready are high in the same cycle (handshake).
REQ-028 WB handshake: if lc_out_idx equals captured out_last, go to FIN; otherwise increment lc_out_idx and go to CLR.
REQ-029 FIN: lc_done=1 for one cycle, then IDLE.
REQ-030 lc_start outside IDLE SHALL be ignored; lc_in_last and lc_out_last changes after capture SHALL have no effect.
REQ-031 Indices SHALL never wrap: in_last=2^IN_W-1 runs exactly 2^IN_W MAC cycles; captured comparisons are equality only.
REQ-032 in_last=0 SHALL give one RUN cycle; out_last=0 SHALL give one neuron.
REQ-033 Per-neuron latency from entering CLR to first lc_res_valid SHALL be 1+(in_last+1)+MAC_LAT cycles.
REQ-034 lc_acc_clr, lc_mac_en, lc_res_valid and lc_done SHALL be mutually exclusive.

Reset
REQ-035 lc_rst=1 at any clock edge, including mid-operation, SHALL force IDLE.
REQ-036 lc_rst SHALL zero every output and the captured limits; no pending result or done pulse is emitted after reset.
REQ-037 lc_rst SHALL take priority over lc_start in the same cycle.

Structure
REQ-038 Package fcl_loop_pkg SHALL hold the FSM state enum typedef and the MAC_LAT default constant.
REQ-039 Sub-module loop_idx_cnt (sync clear, increment, equality-to-last flag) SHALL be instantiated twice, for the input index and the neuron index.
REQ-040 The drain counter SHALL be a 4-bit register inside fcl_loop_ctrl.

Verification
REQ-041 in_last=3, out_last=1, MAC_LAT=2, ready tied 1, start in cycle 0 -> acc_clr in cycles 1 and 9; mac_en in cycles 2-5 and 10-13 with in_idx 0,1,2,3; res_valid in cycle 8 (idx 0) and cycle 16 (idx 1); done in cycle 17.
REQ-042 Same setup, ready low in cycles 8-10 -> res_valid and res_idx=0 held in cycles 8-11, handshake in cycle 11, next acc_clr in cycle 12.
REQ-043 in_last=0, out_last=0, MAC_LAT=0 -> acc_clr in cycle 1, mac_en in cycle 2 only, res_valid in cycle 3, done in cycle 4.
REQ-044 lc_rst in cycle 4 of the REQ-041 run -> cycle 5 is IDLE with all outputs 0; a new start runs normally.
REQ-045 lc_start pulsed while busy, and lc_in_last changed mid-run -> no restart and an unchanged MAC count.
REQ-046 IN_W=3, in_last=7 -> 8 mac_en cycles with in_idx 0..7 and no wrap to 0 while mac_en is high.
